stepper_motion_ctrl: RTL and testbench



---
 rtl/stepper_pkg.sv | 24 ++
 rtl/stepper_ramp_gen.sv | 83 ++++++++
 rtl/stepper_motion_ctrl.sv | 113 +++++++++++
 tb/tb_stepper_motion_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// stepper_pkg: shared mode encodings, coil pattern table and FSM states.
// Rev 1.0
`default_nettype none

package stepper_pkg;

  localparam logic [1:0] MODE_WAVE  = 2'd0;
  localparam logic [1:0] MODE_FULL2 = 2'd1;
  localparam logic [1:0] MODE_HALF  = 2'd2;

  // Index 0 is the least-significant nibble.
  localparam logic [7:0][3:0] COIL_PATTERN = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stepper_ramp_gen.sv
// stepper_ramp_gen: step timing with linear-in-interval accel/decel ramp.
// Rev 1.0
`default_nettype none

module stepper_ramp_gen #(
  parameter int INTERVAL_W = 16,
  parameter int STEPS_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  run,
  input  logic                  halt,
  input  logic [STEPS_W-1:0]    steps,
  input  logic [INTERVAL_W-1:0] start_interval,
  input  logic [INTERVAL_W-1:0] min_interval,
  input  logic [INTERVAL_W-1:0] accel,
  output logic                  step,
  output logic                  last
);

  logic [INTERVAL_W-1:0] cnt, cur_iv, start_iv, min_iv, accel_q;
  logic [STEPS_W-1:0]    remaining, ramp_cnt;

  logic [STEPS_W-1:0]    remaining_nxt;
  logic [INTERVAL_W:0]   iv_up, iv_dn;
  logic                  decel;
  logic [INTERVAL_W-1:0] iv_next;
  logic [STEPS_W-1:0]    ramp_next;

  assign step          = run & ~halt & (cnt == cur_iv);
  assign last          = (remaining == STEPS_W'(1));
  assign remaining_nxt = remaining - STEPS_W'(1);
  assign iv_up         = {1'b0, cur_iv} + {1'b0, accel_q};
  assign iv_dn         = {1'b0, cur_iv} - {1'b0, accel_q};
  assign decel         = (remaining_nxt <= ramp_cnt) && (ramp_cnt != '0);

  // Deceleration mirrors the acceleration: one ramp step undone per step taken.
  always_comb begin
    iv_next   = cur_iv;
    ramp_next = ramp_cnt;
    if (decel) begin
      iv_next   = (iv_up > {1'b0, start_iv}) ? start_iv : iv_up[INTERVAL_W-1:0];
      ramp_next = ramp_cnt - STEPS_W'(1);
    end else if (cur_iv > min_iv) begin
      iv_next   = (iv_dn[INTERVAL_W] || (iv_dn < {1'b0, min_iv})) ? min_iv
                                                                   : iv_dn[INTERVAL_W-1:0];
      ramp_next = ramp_cnt + STEPS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cur_iv    <= '0;
      start_iv  <= '0;
      min_iv    <= '0;
      accel_q   <= '0;
      remaining <= '0;
      ramp_cnt  <= '0;
    end else if (load) begin
      cnt       <= '0;
      cur_iv    <= start_interval;
      start_iv  <= start_interval;
      min_iv    <= min_interval;
      accel_q   <= accel;
      remaining <= steps;
      ramp_cnt  <= '0;
    end else if (step) begin
      cnt       <= '0;
      remaining <= remaining_nxt;
      if (!last) begin
        cur_iv   <= iv_next;
        ramp_cnt <= ramp_next;
      end
    end else if (run && !halt) begin
      cnt <= cnt + INTERVAL_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/stepper_motion_ctrl.sv
// stepper_motion_ctrl: command handshake, coil sequencing and position tracking.
// Rev 1.0
`default_nettype none

module stepper_motion_ctrl
  import stepper_pkg::*;
#(
  parameter int INTERVAL_W = 16,
  parameter int STEPS_W    = 16,
  parameter int POS_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [STEPS_W-1:0]    cmd_steps,
  input  logic                  cmd_reverse,
  input  logic [INTERVAL_W-1:0] cmd_start_interval,
  input  logic [INTERVAL_W-1:0] cmd_min_interval,
  input  logic [INTERVAL_W-1:0] cmd_accel,
  input  logic                  abort,
  output logic [3:0]            coil_drv,
  output logic                  step_pulse,
  output logic                  busy,
  output logic                  done,
  output logic [POS_W-1:0]      position
);

  state_t     state;
  logic [2:0] phase_idx, phase_nxt, phase_delta;
  logic       half_q, reverse_q;
  logic       accept, halt, load, step, last;

  assign cmd_ready   = (state == ST_IDLE) & enable;
  assign busy        = (state == ST_RUN);
  assign accept      = cmd_valid & cmd_ready;
  assign halt        = abort | ~enable;
  assign load        = accept & (cmd_steps != '0);
  assign phase_delta = half_q ? 3'd1 : 3'd2;

  stepper_ramp_gen #(
    .INTERVAL_W (INTERVAL_W),
    .STEPS_W    (STEPS_W)
  ) u_ramp (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .run            (busy),
    .halt           (halt),
    .steps          (cmd_steps),
    .start_interval (cmd_start_interval),
    .min_interval   (cmd_min_interval),
    .accel          (cmd_accel),
    .step           (step),
    .last           (last)
  );

  // Wave lives on even phases, two-phase on odd; half-step keeps the current phase.
  always_comb begin
    phase_nxt = phase_idx;
    if (accept) begin
      case (mode)
        MODE_WAVE:  phase_nxt = {phase_idx[2:1], 1'b0};
        MODE_FULL2: phase_nxt = {phase_idx[2:1], 1'b1};
        default:    phase_nxt = phase_idx;
      endcase
    end else if (step) begin
      phase_nxt = reverse_q ? (phase_idx - phase_delta) : (phase_idx + phase_delta);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase_idx  <= 3'd0;
      position   <= '0;
      coil_drv   <= 4'b0000;
      step_pulse <= 1'b0;
      done       <= 1'b0;
      half_q     <= 1'b0;
      reverse_q  <= 1'b0;
    end else begin
      phase_idx  <= phase_nxt;
      coil_drv   <= enable ? COIL_PATTERN[phase_nxt] : 4'b0000;
      step_pulse <= step;
      done       <= 1'b0;
      if (step)
        position <= reverse_q ? (position - POS_W'(1)) : (position + POS_W'(1));
      case (state)
        ST_IDLE: begin
          if (accept) begin
            half_q    <= mode[1];
            reverse_q <= cmd_reverse;
            if (cmd_steps == '0) done  <= 1'b1;
            else                 state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt || (step && last)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stepper_motion_ctrl.sv
// tb_stepper_motion_ctrl: directed vectors with hand-computed expectations.
// Rev 1.0
`default_nettype none

module tb_stepper_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_reverse = 1'b0;
  logic [15:0] cmd_start_interval = '0;
  logic [15:0] cmd_min_interval = '0;
  logic [15:0] cmd_accel = '0;
  logic        abort = 1'b0;
  logic [3:0]  coil_drv;
  logic        step_pulse;
  logic        busy;
  logic        done;
  logic [23:0] position;

  stepper_motion_ctrl #(
    .INTERVAL_W (16),
    .STEPS_W    (16),
    .POS_W      (24)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .mode               (mode),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_steps          (cmd_steps),
    .cmd_reverse        (cmd_reverse),
    .cmd_start_interval (cmd_start_interval),
    .cmd_min_interval   (cmd_min_interval),
    .cmd_accel          (cmd_accel),
    .abort              (abort),
    .coil_drv           (coil_drv),
    .step_pulse         (step_pulse),
    .busy               (busy),
    .done               (done),
    .position           (position)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         pk [128];
  logic [3:0] pc [128];
  int         npulse;
  int         done_k;

  logic [3:0] half_coils [10] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100,
                                  4'b1000, 4'b1001, 4'b0001, 4'b0011, 4'b0010};
  logic [3:0] wave_coils [3]  = '{4'b1000, 4'b0100, 4'b0010};
  int         ramp_k [8]      = '{12, 21, 28, 33, 38, 45, 54, 65};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns positioned in cycle T+1 after the accept edge T.
  task automatic issue(input logic [1:0] m, input logic rev, input int steps,
                       input int start_iv, input int min_iv, input int acc);
    mode               = m;
    cmd_reverse        = rev;
    cmd_steps          = 16'(steps);
    cmd_start_interval = 16'(start_iv);
    cmd_min_interval   = 16'(min_iv);
    cmd_accel          = 16'(acc);
    cmd_valid          = 1'b1;
    tick();
    cmd_valid          = 1'b0;
  endtask

  // Records pulse cycles (relative to T) until done or the budget runs out.
  task automatic collect(input int maxk);
    npulse = 0;
    done_k = 0;
    for (int k = 1; k <= maxk; k++) begin
      if (step_pulse && npulse < 128) begin
        pk[npulse] = k;
        pc[npulse] = coil_drv;
        npulse++;
      end
      if (done) begin
        done_k = k;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_coil", coil_drv, 4'b0000);
    check("rst_pos", position, 24'h0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_coil", coil_drv, 4'b0001);
    check("idle_ready", cmd_ready, 1'b1);
    check("idle_done", done, 1'b0);
    check("idle_pulse", step_pulse, 1'b0);
    enable = 1'b0;
    tick();
    check("dis_coil", coil_drv, 4'b0000);
    check("dis_ready", cmd_ready, 1'b0);
    enable = 1'b1;
    tick();
    check("en_coil", coil_drv, 4'b0001);

    // Half-step, constant rate, interval 3
    issue(2'd2, 1'b0, 10, 3, 3, 0);
    check("half_busy", busy, 1'b1);
    collect(60);
    check("half_npulse", npulse, 10);
    for (int n = 0; n < 10; n++) begin
      check($sformatf("half_k%0d", n), pk[n], 5 + 4 * n);
      check($sformatf("half_coil%0d", n), pc[n], half_coils[n]);
    end
    check("half_done_k", done_k, 41);
    tick();
    check("half_pos", position, 24'd10);
    check("half_busy_end", busy, 1'b0);
    check("half_done_end", done, 1'b0);

    // Two-phase zero-step command: parity forced odd, done only
    issue(2'd1, 1'b0, 0, 5, 5, 0);
    check("zero_done", done, 1'b1);
    check("zero_pulse", step_pulse, 1'b0);
    check("zero_busy", busy, 1'b0);
    check("zero_coil", coil_drv, 4'b0110);
    tick();
    check("zero_done_end", done, 1'b0);
    check("zero_pos", position, 24'd10);

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check("rst2_coil", coil_drv, 4'b0001);
    check("rst2_pos", position, 24'h0);

    // Wave, reverse, one step per clock
    issue(2'd0, 1'b1, 3, 0, 0, 0);
    collect(10);
    check("wave_npulse", npulse, 3);
    for (int n = 0; n < 3; n++) begin
      check($sformatf("wave_k%0d", n), pk[n], 2 + n);
      check($sformatf("wave_coil%0d", n), pc[n], wave_coils[n]);
    end
    check("wave_done_k", done_k, 4);
    tick();
    check("wave_pos", position, 24'hFFFFFD);

    // Two-phase ramp: periods 11,9,7,5,5,7,9,11
    issue(2'd1, 1'b0, 8, 10, 4, 2);
    collect(100);
    check("ramp_npulse", npulse, 8);
    for (int n = 0; n < 8; n++)
      check($sformatf("ramp_k%0d", n), pk[n], ramp_k[n]);
    check("ramp_done_k", done_k, 65);
    check("ramp_last_coil", pc[7], 4'b0110);
    tick();
    check("ramp_pos", position, 24'd5);

    // Abort after second step, in the cycle a third step would fire
    issue(2'd2, 1'b0, 100, 1, 1, 0);
    repeat (4) tick();
    check("abort_pulse2", step_pulse, 1'b1);
    tick();
    check("abort_gap", step_pulse, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done", done, 1'b1);
    check("abort_pulse", step_pulse, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_pos", position, 24'd7);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_coil", coil_drv, 4'b1100);
    tick();
    check("abort_done_end", done, 1'b0);

    // Enable dropped after second step
    issue(2'd2, 1'b0, 100, 1, 1, 0);
    repeat (4) tick();
    check("en_pulse2", step_pulse, 1'b1);
    tick();
    enable = 1'b0;
    tick();
    check("endrop_done", done, 1'b1);
    check("endrop_pulse", step_pulse, 1'b0);
    check("endrop_coil", coil_drv, 4'b0000);
    check("endrop_pos", position, 24'd9);
    check("endrop_ready", cmd_ready, 1'b0);
    enable = 1'b1;
    tick();
    check("reen_coil", coil_drv, 4'b1001);
    check("reen_ready", cmd_ready, 1'b1);

    // Command while busy is ignored; then async reset mid-move
    issue(2'd0, 1'b0, 50, 2, 2, 0);
    cmd_steps = 16'd0;
    cmd_valid = 1'b1;
    check("busy_ready", cmd_ready, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("busy_ignore_done", done, 1'b0);
    check("busy_ignore_busy", busy, 1'b1);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_coil", coil_drv, 4'b0000);
    check("mid_rst_pos", position, 24'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pulse", step_pulse, 1'b0);
    check("mid_rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_coil", coil_drv, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
